cordic_iter_engine: RTL and testbench
=====================================

# cordic_iter_engine

Sequential CORDIC iteration engine for the NN inference datapath. Accepts one (x, y, z) operand triple, runs one micro-rotation per clock using arithmetic right shifts, and returns the result under a valid/ready handshake. Linear mode computes the MAC term `y + x·z` for neuron accumulation. Hyperbolic mode computes cosh/sinh of z for activation functions. It sits directly downstream of the operand/shift-amount stage and upstream of the activation/accumulator logic.

## Interface
- `WIDTH`, 15: MSB index of data words; data are WIDTH+1 bits signed.
- `FRAC`, 12: fractional bits (Q3.12 at defaults).
- `ITER`, 14: base iteration count; the shift amount must fit 4 bits (ITER ≤ 15).

Ports:
- `clk` in 1: clock. One clock; reset is synchronous and active-low.
- `rst_n` in 1: synchronous active-low reset.
- `in_valid` in 1: operand triple valid.
- `in_ready` out 1: engine can accept; high only in IDLE.
- `mode` in 1: 1 = linear (shift = i), 0 = hyperbolic; sampled at accept.
- `x_in`, `y_in`, `z_in` in WIDTH+1: signed operands.
- `out_valid` out 1: result valid; held until consumed.
- `out_ready` in 1: consumer accepts the result.
- `x_out`, `y_out`, `z_out` out WIDTH+1: signed results.

## Operation
- FSM: IDLE → RUN on accept (`in_valid & in_ready`). RUN → DONE after the last iteration. DONE → IDLE on `out_valid & out_ready`.
- Accept edge: load x, y, z into internal registers that are WIDTH+3 bits (2 guard bits, sign-extended). Latch `mode`. Clear the iteration counter.
- Each RUN cycle: d = +1 if z ≥ 0, else −1. sx = x>>>s and sy = y>>>s, both arithmetic.
  - Linear: x unchanged; y += d·sx; z −= d·(1<<(FRAC−s)), and this z term is 0 when s > FRAC.
  - Hyperbolic: x += d·sy; y += d·sx; z −= d·atanh(2^−s) in Q.FRAC, rounded to nearest, from ROM.
- Shift sequence:
  - Linear: s = 0,1,…,ITER−1, which is N_lin = ITER iterations.
  - Hyperbolic: s = 1,2,…,ITER, with s=4 and s=13 each executed twice when ≤ ITER. That gives N_hyp = ITER+2 = 16 at the default.
- No gain compensation. For hyperbolic mode the caller preloads x_in = 1/K_h, which is 4946 at defaults.
- Outputs are registered and change only on the RUN→DONE edge. They are stable throughout DONE.
- Reset, from any state including mid-RUN: state=IDLE, all internal registers 0, `x_out`/`y_out`/`z_out`=0, `out_valid`=0, `in_ready`=1 on the first cycle with rst_n high.
- `in_valid` and `mode` are ignored outside IDLE.

## Timing
- Latency from accept edge to `out_valid` high is N edges: 14 for linear, 16 for hyperbolic at defaults.
- There is no same-cycle turnaround. After the DONE handshake edge the engine is in IDLE and `in_ready`=1 in the next cycle. Minimum issue interval is N+2 cycles.
- `out_ready` held low: `out_valid` and the data are held indefinitely and `in_ready` stays 0.
- `out_ready` high while out_valid=0 has no effect.

## Configuration
- `CORDIC_SAT_EN` defined: each output is saturated from the guard-bit register to the range [−2^WIDTH, 2^WIDTH−1].
- `CORDIC_SAT_EN` undefined: each output is the low WIDTH+1 bits of the register (two's-complement wrap).

## Structure
- `cordic_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - the mode encoding constants;
  - the guard-bit count;
  - iteration-count helper functions for N_lin and N_hyp.
- Sub-module `cordic_atanh_rom`: combinational 4-bit shift index → WIDTH+1-bit atanh(2^−s) in Q.FRAC.
- The top level holds the FSM, iteration counter, repeat logic and datapath.

## Test plan
All values at defaults (WIDTH=15, FRAC=12, ITER=14).
- Linear MAC: x=2048, y=1024, z=3072 (0.5, 0.25, 0.75) → after 14 cycles y_out=2560±2, x_out=2048, z_out=0±2.
- Hyperbolic: x=4946, y=0, z=2048 (0.5) → after 16 cycles x_out=4619±4 (cosh 0.5), y_out=2134±4 (sinh 0.5), z_out=0±2.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs unchanged and in_ready=0 throughout. Raise out_ready → in_ready=1 exactly one cycle after the handshake edge.
- Saturation: linear with x=30720, y=28672, z=7782 (7.5, 7.0, 1.9):
  - CORDIC_SAT_EN defined → y_out=32767;
  - CORDIC_SAT_EN undefined → y_out equals the wrapped low 16 bits.
- Reset mid-run: assert rst_n=0 at RUN iteration 5 for 1 cycle → next cycle out_valid=0, outputs=0, in_ready=1. A new accept then produces a correct result.
- Back-to-back with mode switch: linear job followed by hyperbolic job → the second job's latency is 16, and mode is ignored while RUN.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared state encoding, mode constants and iteration-count
// helpers for the cordic_iter_engine datapath.
package cordic_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Operating mode as sampled from the mode input at accept.
    localparam logic MODE_LIN = 1'b1;
    localparam logic MODE_HYP = 1'b0;

    // Integer headroom carried above the WIDTH+1-bit data words.
    localparam int GUARD_BITS = 2;

    // Shift index width and iteration counter width (N is at most 17).
    localparam int SHIFT_W = 4;
    localparam int CNT_W   = 5;

    // Hyperbolic shift indices that must be executed twice for convergence.
    localparam logic [SHIFT_W-1:0] HYP_REP_A = 4'd4;
    localparam logic [SHIFT_W-1:0] HYP_REP_B = 4'd13;

    // Number of linear micro-rotations: s = 0 .. iter-1.
    function automatic int n_lin(input int iter);
        return iter;
    endfunction

    // Number of hyperbolic micro-rotations: s = 1 .. iter plus the repeats.
    function automatic int n_hyp(input int iter);
        return iter + ((iter >= 4) ? 1 : 0) + ((iter >= 13) ? 1 : 0);
    endfunction

endpackage

// File: rtl/cordic_atanh_rom.sv
// cordic_atanh_rom: combinational table of atanh(2^-s) in Q.FRAC, rounded
// to nearest. Constants are held in Q2.30 and rounded down to FRAC bits.
module cordic_atanh_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int FRAC  = 12
) (
    input  logic [SHIFT_W-1:0] shift_i,
    output logic signed [WIDTH:0] atanh_o
);

    localparam int          DW  = WIDTH + 1;
    localparam int          RSH = 30 - FRAC;
    localparam logic [31:0] RND = 32'(1) << (RSH - 1);

    logic [31:0] q30;

    // Look up the Q2.30 reference; s = 0 (atanh(1) is unbounded) is only
    // reached in linear mode, where the table output is not used.
    always_comb begin
        q30 = '0;
        case (shift_i)
            4'd1:    q30 = 32'd589812981;
            4'd2:    q30 = 32'd274247423;
            4'd3:    q30 = 32'd134923403;
            4'd4:    q30 = 32'd67196451;
            4'd5:    q30 = 32'd33565361;
            4'd6:    q30 = 32'd16778582;
            4'd7:    q30 = 32'd8388779;
            4'd8:    q30 = 32'd4194325;
            4'd9:    q30 = 32'd2097155;
            4'd10:   q30 = 32'd1048576;
            4'd11:   q30 = 32'd524288;
            4'd12:   q30 = 32'd262144;
            4'd13:   q30 = 32'd131072;
            4'd14:   q30 = 32'd65536;
            4'd15:   q30 = 32'd32768;
            default: q30 = '0;
        endcase
    end

    // Round half-up to FRAC fractional bits.
    assign atanh_o = DW'((q30 + RND) >> RSH);

endmodule

// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine: sequential CORDIC engine, one micro-rotation per clock.
// Linear mode yields y + x*z, hyperbolic mode yields cosh/sinh of z (caller
// preloads x = 1/K_h). Optional macro CORDIC_SAT_EN saturates the outputs
// instead of wrapping them to WIDTH+1 bits.
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int FRAC  = 12,
    parameter int ITER  = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic signed [WIDTH:0] x_in,
    input  logic signed [WIDTH:0] y_in,
    input  logic signed [WIDTH:0] z_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [WIDTH:0] x_out,
    output logic signed [WIDTH:0] y_out,
    output logic signed [WIDTH:0] z_out
);

    localparam int GW = WIDTH + 1 + GUARD_BITS;
    localparam logic [CNT_W-1:0] LAST_LIN = CNT_W'(n_lin(ITER) - 1);
    localparam logic [CNT_W-1:0] LAST_HYP = CNT_W'(n_hyp(ITER) - 1);
    // 1.0 in Q.FRAC; shifting right by s gives 2^-s and naturally reaches 0 for s > FRAC.
    localparam logic signed [GW-1:0] Z_ONE = GW'(2 ** FRAC);

    state_t              state_q;
    logic                mode_q;
    logic                rep_q, rep_d;
    logic [SHIFT_W-1:0]  s_q, s_d;
    logic [CNT_W-1:0]    cnt_q;
    logic signed [GW-1:0] x_q, y_q, z_q;
    logic signed [GW-1:0] x_d, y_d, z_d;
    logic signed [GW-1:0] sx, sy, z_step, rom_ext;
    logic signed [WIDTH:0] rom_atanh;
    logic signed [WIDTH:0] x_fit, y_fit, z_fit;
    logic signed [WIDTH:0] x_out_q, y_out_q, z_out_q;
    logic                in_ready_q, out_valid_q;
    logic                d_pos, last_iter;

    cordic_atanh_rom #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rom (
        .shift_i (s_q),
        .atanh_o (rom_atanh)
    );

    assign rom_ext   = {{GUARD_BITS{rom_atanh[WIDTH]}}, rom_atanh};
    assign last_iter = (cnt_q == ((mode_q == MODE_LIN) ? LAST_LIN : LAST_HYP));

    // One micro-rotation: direction from the sign of z, arithmetic shifts of x and y.
    always_comb begin
        d_pos  = ~z_q[GW-1];
        sx     = x_q >>> s_q;
        sy     = y_q >>> s_q;
        z_step = (mode_q == MODE_LIN) ? (Z_ONE >> s_q) : rom_ext;
        y_d    = d_pos ? (y_q + sx) : (y_q - sx);
        z_d    = d_pos ? (z_q - z_step) : (z_q + z_step);
        if (mode_q == MODE_LIN) begin
            x_d = x_q;
        end else begin
            x_d = d_pos ? (x_q + sy) : (x_q - sy);
        end
    end

    // Next shift index; hyperbolic indices 4 and 13 are run a second time.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        s_d   = s_q + 4'd1;
        rep_d = 1'b0;
        if (mode_q == MODE_HYP && !rep_q && (s_q == HYP_REP_A || s_q == HYP_REP_B)) begin
            s_d   = s_q;
            rep_d = 1'b1;
        end
    end

`ifdef CORDIC_SAT_EN
    function automatic logic signed [WIDTH:0] sat_word(input logic signed [GW-1:0] v);
        if (v[GW-1:WIDTH] == {(GUARD_BITS + 1){v[GW-1]}}) begin
            return v[WIDTH:0];
        end
        return v[GW-1] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, {WIDTH{1'b1}}};
    endfunction

    assign x_fit = sat_word(x_d);
    assign y_fit = sat_word(y_d);
    assign z_fit = sat_word(z_d);
`else
    assign x_fit = x_d[WIDTH:0];
    assign y_fit = y_d[WIDTH:0];
    assign z_fit = z_d[WIDTH:0];
`endif

    // Control FSM, iteration state and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            rep_q       <= 1'b0;
            s_q         <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            z_out_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        x_q        <= {{GUARD_BITS{x_in[WIDTH]}}, x_in};
                        y_q        <= {{GUARD_BITS{y_in[WIDTH]}}, y_in};
                        z_q        <= {{GUARD_BITS{z_in[WIDTH]}}, z_in};
                        mode_q     <= mode;
                        s_q        <= (mode == MODE_LIN) ? 4'd0 : 4'd1;
                        rep_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    z_q   <= z_d;
                    s_q   <= s_d;
                    rep_q <= rep_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        x_out_q     <= x_fit;
                        y_out_q     <= y_fit;
                        z_out_q     <= z_fit;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = z_out_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine: directed vectors with hand-computed results for the
// default configuration (WIDTH=15, FRAC=12, ITER=14), plus sequences for
// backpressure, reset during RUN and back-to-back jobs with a mode switch.
module tb_cordic_iter_engine;

    localparam int N_LIN = 14;
    localparam int N_HYP = 16;
`ifdef CORDIC_SAT_EN
    localparam int SAT_Y   = 32767;
    localparam int SAT_TOL = 0;
`else
    localparam int SAT_Y   = 21505;
    localparam int SAT_TOL = 2;
`endif

    typedef struct {
        string name;
        logic  mode;
        int    x, y, z;
        int    ex, ey, ez;
        int    tx, ty, tz;
        int    lat;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mode = 1'b0;
    logic signed [15:0] x_in = '0, y_in = '0, z_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [15:0] x_out, y_out, z_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    vec_t vecs[6];

    cordic_iter_engine #(.WIDTH(15), .FRAC(12), .ITER(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string name, input logic m, input int x, input int y,
                                input int z, input int ex, input int ey, input int ez,
                                input int tx, input int ty, input int tz, input int lat);
        vec_t v;
        v.name = name; v.mode = m; v.x = x; v.y = y; v.z = z;
        v.ex = ex; v.ey = ey; v.ez = ez; v.tx = tx; v.ty = ty; v.tz = tz; v.lat = lat;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Issue one job; returns edges from accept to out_valid and the accept cycle.
    task automatic run_job(input vec_t v, input bit jam, input bit rdy,
                           output int lat, output int acc_cyc);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check($sformatf("%s_ready", v.name), int'(in_ready), 1, 0);
        in_valid  = 1'b1;
        mode      = v.mode;
        x_in      = 16'(v.x);
        y_in      = 16'(v.y);
        z_in      = 16'(v.z);
        out_ready = rdy;
        tick();
        acc_cyc = cyc;
        if (jam) begin
            in_valid = 1'b1;
            mode     = ~v.mode;
            x_in     = 16'sd1000;
            y_in     = -16'sd1000;
            z_in     = 16'sd500;
        end else begin
            in_valid = 1'b0;
        end
        check($sformatf("%s_busy", v.name), int'(in_ready), 0, 0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        mode     = 1'b0;
    endtask

    task automatic check_result(input vec_t v, input int lat);
        check($sformatf("%s_valid", v.name), int'(out_valid), 1, 0);
        check($sformatf("%s_lat", v.name), lat, v.lat, 0);
        check($sformatf("%s_x", v.name), int'(x_out), v.ex, v.tx);
        check($sformatf("%s_y", v.name), int'(y_out), v.ey, v.ty);
        check($sformatf("%s_z", v.name), int'(z_out), v.ez, v.tz);
    endtask

    // Consume the result and confirm IDLE is reached one cycle after the handshake edge.
    task automatic finish_job(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("%s_done_valid", name), int'(out_valid), 0, 0);
        check($sformatf("%s_done_ready", name), int'(in_ready), 1, 0);
    endtask

    initial begin
        int lat, a1, a2;

        vecs[0] = mk("lin_mac",  1'b1,  2048, 1024,  3072,  2048,  2560, 0, 0, 2, 2, N_LIN);
        vecs[1] = mk("hyp_pos",  1'b0,  4946,    0,  2048,  4619,  2134, 0, 4, 4, 2, N_HYP);
        vecs[2] = mk("lin_negx", 1'b1, -2048, 1024,  2048, -2048,     0, 0, 0, 2, 2, N_LIN);
        vecs[3] = mk("hyp_neg",  1'b0,  4946,    0, -2048,  4619, -2134, 0, 4, 4, 2, N_HYP);
        vecs[4] = mk("lin_negz", 1'b1,  4096,    0, -4096,  4096, -4096, 0, 0, 2, 2, N_LIN);
        vecs[5] = mk("lin_sat",  1'b1, 30720, 28672, 7782, 30720, SAT_Y, 0, 0, SAT_TOL, 2, N_LIN);

        // Reset with busy inputs; everything must be cleared once rst_n rises.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        mode     = 1'b1;
        x_in     = 16'sd100;
        tick();
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        mode     = 1'b0;
        x_in     = '0;
        check("rst_valid", int'(out_valid), 0, 0);
        check("rst_ready", int'(in_ready), 1, 0);
        check("rst_x", int'(x_out), 0, 0);
        check("rst_y", int'(y_out), 0, 0);
        check("rst_z", int'(z_out), 0, 0);

        // out_ready while idle has no effect.
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        check("idle_ordy_valid", int'(out_valid), 0, 0);
        check("idle_ordy_ready", int'(in_ready), 1, 0);

        // Table of directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i], 1'b0, 1'b0, lat, a1);
            check_result(vecs[i], lat);
            finish_job(vecs[i].name);
        end

        // Backpressure: result held for 5 cycles while in_valid is asserted with other data.
        run_job(vecs[0], 1'b0, 1'b0, lat, a1);
        check_result(vecs[0], lat);
        in_valid = 1'b1;
        mode     = 1'b0;
        x_in     = 16'sd777;
        y_in     = 16'sd333;
        z_in     = -16'sd99;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp%0d_valid", k), int'(out_valid), 1, 0);
            check($sformatf("bp%0d_ready", k), int'(in_ready), 0, 0);
            check($sformatf("bp%0d_x", k), int'(x_out), 2048, 0);
            check($sformatf("bp%0d_y", k), int'(y_out), 2560, 2);
        end
        in_valid = 1'b0;
        finish_job("bp");

        // out_ready held high through RUN: result appears, then is consumed at once.
        run_job(vecs[1], 1'b0, 1'b1, lat, a1);
        check_result(vecs[1], lat);
        tick();
        out_ready = 1'b0;
        check("autocons_valid", int'(out_valid), 0, 0);
        check("autocons_ready", int'(in_ready), 1, 0);

        // Reset at RUN iteration 5, then a fresh job must still be correct.
        in_valid = 1'b1;
        mode     = 1'b0;
        x_in     = 16'sd4946;
        y_in     = '0;
        z_in     = 16'sd2048;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", int'(out_valid), 0, 0);
        check("midrst_ready", int'(in_ready), 1, 0);
        check("midrst_x", int'(x_out), 0, 0);
        check("midrst_y", int'(y_out), 0, 0);
        check("midrst_z", int'(z_out), 0, 0);
        repeat (20) tick();
        check("midrst_quiet", int'(out_valid), 0, 0);
        run_job(vecs[0], 1'b0, 1'b0, lat, a1);
        check_result(vecs[0], lat);
        finish_job("midrst_job");

        // Back-to-back linear then hyperbolic; mode/in_valid jammed during the second RUN.
        run_job(vecs[2], 1'b0, 1'b0, lat, a1);
        check_result(vecs[2], lat);
        finish_job("b2b_first");
        run_job(vecs[1], 1'b1, 1'b0, lat, a2);
        check_result(vecs[1], lat);
        check("b2b_interval", a2 - a1, N_LIN + 2, 0);
        finish_job("b2b_second");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
